mips_control_fsm: RTL and testbench
===================================

MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 15, the maximum number of consecutive cycles a memory state waits for mem_ready before error.
REQ-002 The block SHALL have port clk  input  1  system clock, all state updated on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-004 The block SHALL have port opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 The block SHALL have port mem_ready  input  1  memory handshake: access completes in the cycle it is high.
REQ-006 The block SHALL have port zero  input  1  ALU zero flag, used only in BRANCH.
REQ-007 The block SHALL have outputs signal_pc_write, signal_pc_write_cond, signal_ir_write, signal_mem_read, signal_mem_write, signal_i_or_d, signal_mem_to_reg, signal_reg_dst, signal_reg_write, signal_alu_src_a  output  1 each  datapath controls; signal_reg_write drives the register file write enable.
REQ-008 The block SHALL have outputs signal_alu_src_b, signal_alu_op, signal_pc_source  output  2 each  datapath mux/ALU selects.
REQ-009 The block SHALL have outputs state  output  4  current state; error  output  1  sticky fault; instr_count  output  32  retired instructions.

Function
REQ-010 States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, ERROR 15; codes 12-14 SHALL transition to ERROR.
REQ-011 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; -> DECODE when mem_ready, else hold.
REQ-012 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 0x23/0x2B -> MEM_ADDR, 0x00 -> EXECUTE, 0x04 -> BRANCH, 0x02 -> JUMP, 0x08 -> ADDI_EXEC, any other -> ERROR.
REQ-013 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; opcode 0x23 -> MEM_READ, 0x2B -> MEM_WRITE.
REQ-014 MEM_READ: mem_read=1, i_or_d=1; -> MEM_WB when mem_ready, else hold.
REQ-015 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; -> FETCH.
REQ-016 MEM_WRITE: mem_write=1, i_or_d=1; -> FETCH when mem_ready, else hold.
REQ-017 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; -> ALU_WB.  ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0; -> FETCH.
REQ-018 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1; -> FETCH regardless of zero.
REQ-019 JUMP: pc_write=1, pc_source=10; -> FETCH.
REQ-020 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; -> ADDI_WB.  ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; -> FETCH.
REQ-021 Every control output not listed for a state SHALL be 0 in that state; outputs other than ir_write/pc_write in FETCH SHALL depend on state only.
REQ-022 Wait counter: cleared on entry to FETCH, MEM_READ, MEM_WRITE; increments each cycle in those states with mem_ready=0; reaching MEM_TIMEOUT with mem_ready=0 SHALL go to ERROR on that edge; mem_ready=1 on the same cycle takes precedence (normal transition).
REQ-023 ERROR: all controls 0, error=1; state held until rst.
REQ-024 instr_count SHALL increment by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JUMP, ADDI_WB; wraps 0xFFFFFFFF -> 0.
REQ-025 Cycle counts: R-type/addi 4, lw 5, sw 4, beq 3, j 3, each plus memory wait cycles.

Reset
REQ-026 rst high SHALL immediately force state=FETCH, error=0, instr_count=0, wait counter=0, independent of clk.
REQ-027 rst asserted mid-instruction (including with reg_write high in ALU_WB) SHALL deassert reg_write/mem_write immediately; no partial instruction is counted.
REQ-028 After rst falls, FETCH behaviour SHALL begin at the next rising edge.

Verification
REQ-029 rst, mem_ready=1, opcode=0x00 -> states 0,1,6,7,0; reg_write=1,reg_dst=1 only in state 7; instr_count=1.
REQ-030 opcode=0x23, mem_ready low 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0; reg_write=1,mem_to_reg=1 in state 4; 8 cycles total.
REQ-031 opcode=0x04, zero=1 then zero=0 -> each 3 cycles; pc_write_cond=1, pc_source=01 in state 8; instr_count=2.
REQ-032 opcode=0x3F -> DECODE then ERROR(15), error=1, all controls 0 for 20 cycles; rst restores state 0.
REQ-033 MEM_TIMEOUT=15, mem_ready=0 in FETCH -> ERROR after 15 cycles; mem_ready=1 on 15th cycle -> DECODE instead.
REQ-034 rst pulsed asynchronously between edges while in ALU_WB -> state=0, reg_write=0 before next edge, instr_count unchanged.

Source files
------------

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control unit: sequences FETCH..writeback per opcode and drives datapath controls.
// Latency: R-type/addi/sw 4 cycles, lw 5, beq/j 3, plus one cycle per memory wait; outputs are Moore
//          (except ir_write/pc_write in FETCH, which follow mem_ready). Backpressure: memory states hold
//          until mem_ready, and fall into a sticky ERROR after MEM_TIMEOUT consecutive stalled cycles.
//
// Ports:
//   clk, rst (async, active-high)     - clock and reset; reset forces FETCH and clears counters at once
//   opcode[5:0]                       - instruction bits [31:26] from the instruction register
//   mem_ready                         - memory access completes in the cycle it is high
//   zero                              - ALU zero flag; the datapath gates the branch with pc_write_cond
//   signal_*                          - datapath write enables, mux selects and ALU op
//   state[3:0], error, instr_count    - current state, sticky fault, retired instruction count
module mips_control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        signal_pc_write,
    output logic        signal_pc_write_cond,
    output logic        signal_ir_write,
    output logic        signal_mem_read,
    output logic        signal_mem_write,
    output logic        signal_i_or_d,
    output logic        signal_mem_to_reg,
    output logic        signal_reg_dst,
    output logic        signal_reg_write,
    output logic        signal_alu_src_a,
    output logic [1:0]  signal_alu_src_b,
    output logic [1:0]  signal_alu_op,
    output logic [1:0]  signal_pc_source,
    output logic [3:0]  state,
    output logic        error,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_ERROR     = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // The counter only needs to reach MEM_TIMEOUT-1: the stalled cycle that would
    // make it MEM_TIMEOUT is the one that jumps to ERROR instead.
    localparam int              WAIT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [31:0]         instr_count_q, instr_count_d;

    logic wait_expired;
    logic mem_state;
    logic retire;

    // The branch decision is made by the datapath from zero and pc_write_cond.
    logic unused_zero;
    assign unused_zero = zero;

    assign wait_expired = (wait_q == WAIT_MAX);
    assign mem_state    = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                          (state_q == S_MEM_WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FETCH;
            wait_q        <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)         state_d = S_DECODE;
                else if (wait_expired) state_d = S_ERROR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      state_d = S_MEM_READ;
                else if (opcode == OP_SW) state_d = S_MEM_WRITE;
                else                      state_d = S_ERROR;
            end
            S_MEM_READ: begin
                if (mem_ready)         state_d = S_MEM_WB;
                else if (wait_expired) state_d = S_ERROR;
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: begin
                if (mem_ready)         state_d = S_FETCH;
                else if (wait_expired) state_d = S_ERROR;
            end
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_ERROR:     state_d = S_ERROR;
            default:     state_d = S_ERROR;
        endcase
    end

    // A memory state only re-enters itself while stalled, so "staying put" is the
    // increment condition and any state change is an entry that clears the count.
    always_comb begin
        wait_d = '0;
        if (mem_state && (state_d == state_q)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Retire on the return to FETCH from any final state of an instruction.
    always_comb begin
        retire = 1'b0;
        if (state_d == S_FETCH) begin
            case (state_q)
                S_MEM_WB, S_MEM_WRITE, S_ALU_WB,
                S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
                default:                     retire = 1'b0;
            endcase
        end
        instr_count_d = retire ? instr_count_q + 32'd1 : instr_count_q;
    end

    // Control outputs: decoded from state_q only, so reset drops them immediately.
    always_comb begin
        signal_pc_write      = 1'b0;
        signal_pc_write_cond = 1'b0;
        signal_ir_write      = 1'b0;
        signal_mem_read      = 1'b0;
        signal_mem_write     = 1'b0;
        signal_i_or_d        = 1'b0;
        signal_mem_to_reg    = 1'b0;
        signal_reg_dst       = 1'b0;
        signal_reg_write     = 1'b0;
        signal_alu_src_a     = 1'b0;
        signal_alu_src_b     = 2'b00;
        signal_alu_op        = 2'b00;
        signal_pc_source     = 2'b00;
        case (state_q)
            S_FETCH: begin
                signal_mem_read  = 1'b1;
                signal_alu_src_b = 2'b01;
                signal_ir_write  = mem_ready;
                signal_pc_write  = mem_ready;
            end
            S_DECODE: begin
                signal_alu_src_b = 2'b11;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                signal_alu_src_a = 1'b1;
                signal_alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                signal_mem_read = 1'b1;
                signal_i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                signal_reg_write  = 1'b1;
                signal_mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                signal_mem_write = 1'b1;
                signal_i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                signal_alu_src_a = 1'b1;
                signal_alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                signal_reg_write = 1'b1;
                signal_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                signal_alu_src_a     = 1'b1;
                signal_alu_op        = 2'b01;
                signal_pc_source     = 2'b01;
                signal_pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                signal_pc_write  = 1'b1;
                signal_pc_source = 2'b10;
            end
            S_ADDI_WB: begin
                signal_reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign state       = state_q;
    assign error       = (state_q == S_ERROR);
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Testbench for mips_control_fsm: directed instruction sequences, reset and timeout
// corners, then randomized instruction streams, all checked through a scoreboard queue.
module tb_mips_control_fsm;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        zero;
    logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        error;
    logic [31:0] instr_count;

    mips_control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .opcode               (opcode),
        .mem_ready            (mem_ready),
        .zero                 (zero),
        .signal_pc_write      (pc_write),
        .signal_pc_write_cond (pc_write_cond),
        .signal_ir_write      (ir_write),
        .signal_mem_read      (mem_read),
        .signal_mem_write     (mem_write),
        .signal_i_or_d        (i_or_d),
        .signal_mem_to_reg    (mem_to_reg),
        .signal_reg_dst       (reg_dst),
        .signal_reg_write     (reg_write),
        .signal_alu_src_a     (alu_src_a),
        .signal_alu_src_b     (alu_src_b),
        .signal_alu_op        (alu_op),
        .signal_pc_source     (pc_source),
        .state                (state),
        .error                (error),
        .instr_count          (instr_count)
    );

    always #5 clk = ~clk;

    logic [15:0] act_ctrl;
    assign act_ctrl = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // An instruction is a list of phases chosen by its opcode once fetched; memory
    // phases (fetch, read, write) stall on mem_ready and time out after TO stalls.
    int          m_state;
    int          m_path[$];
    int          m_wait;
    logic [31:0] m_count;

    function automatic logic [15:0] exp_ctrl(int s, logic mr);
        logic pcw = 0, pcwc = 0, irw = 0, mrd = 0, mwr = 0, iod = 0;
        logic m2r = 0, rdst = 0, rw = 0, asa = 0;
        logic [1:0] asb = 0, aop = 0, psrc = 0;
        case (s)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pcwc = 1; end
            9:  begin pcw = 1; psrc = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, irw, mrd, mwr, iod, m2r, rdst, rw, asa, asb, aop, psrc};
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_path.delete();
        m_wait  = 0;
        m_count = 0;
    endfunction

    function automatic void model_step(logic [5:0] op, logic mr);
        if (m_state == 15) return;
        if ((m_state == 0 || m_state == 3 || m_state == 5) && !mr) begin
            m_wait++;
            if (m_wait == TO) m_state = 15;
            return;
        end
        m_wait = 0;
        if (m_state == 0) begin
            case (op)
                6'h00:   m_path = '{6, 7};
                6'h23:   m_path = '{2, 3, 4};
                6'h2B:   m_path = '{2, 5};
                6'h04:   m_path = '{8};
                6'h02:   m_path = '{9};
                6'h08:   m_path = '{10, 11};
                default: m_path = '{15};
            endcase
            m_state = 1;
        end else if (m_path.size() == 0) begin
            m_state = 0;
            m_count = m_count + 32'd1;
        end else begin
            m_state = m_path.pop_front();
        end
    endfunction

    // ---------------- stimulus ----------------
    // Called at posedge+1: drive this cycle's inputs, queue the expected outputs,
    // advance the model across the coming edge.
    task automatic step(input logic [5:0] op, input logic mr, input logic z);
        exp_t e;
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        e.st   = 4'(m_state);
        e.ctrl = exp_ctrl(m_state, mr);
        e.err  = (m_state == 15);
        e.cnt  = m_count;
        exp_q.push_back(e);
        model_step(op, mr);
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between clock edges and check its immediate effect.
    task automatic do_reset();
        logic [15:0] c;
        #2;
        c = exp_ctrl(m_state, mem_ready);
        check("pre_rst_state", {28'd0, state}, m_state);
        check("pre_rst_reg_write", {31'd0, reg_write}, {31'd0, c[7]});
        rst = 1'b1;
        #1;
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_reg_write", {31'd0, reg_write}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_instr_count", instr_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t me;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                check("state", {28'd0, state}, {28'd0, me.st});
                check("ctrl", {16'd0, act_ctrl}, {16'd0, me.ctrl});
                check("error", {31'd0, error}, {31'd0, me.err});
                check("instr_count", instr_count, me.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        logic [5:0] cur_op;
        int errc;

        rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0; zero = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {28'd0, state}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_instr_count", instr_count, 32'd0);
        rst = 1'b0;

        // R-type: 0,1,6,7 then back to FETCH with one retired
        repeat (4) step(6'h00, 1'b1, 1'b0);
        // lw with three stalled MEM_READ cycles
        repeat (3) step(6'h23, 1'b1, 1'b0);
        repeat (3) step(6'h23, 1'b0, 1'b0);
        repeat (2) step(6'h23, 1'b1, 1'b0);
        // beq taken then not taken
        repeat (3) step(6'h04, 1'b1, 1'b1);
        repeat (3) step(6'h04, 1'b1, 1'b0);
        // sw, j, addi
        repeat (4) step(6'h2B, 1'b1, 1'b0);
        repeat (3) step(6'h02, 1'b1, 1'b0);
        repeat (4) step(6'h08, 1'b1, 1'b0);
        // reset between edges while sitting in ALU_WB
        repeat (3) step(6'h00, 1'b1, 1'b0);
        do_reset();
        // illegal opcode: DECODE then sticky ERROR
        repeat (2) step(6'h3F, 1'b1, 1'b0);
        repeat (20) step(6'h3F, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        do_reset();
        // fetch timeout, then ERROR held regardless of mem_ready
        repeat (TO) step(6'h00, 1'b0, 1'b0);
        repeat (3) step(6'h00, 1'b1, 1'b0);
        do_reset();
        // ready arrives on the last permitted cycle
        repeat (TO - 1) step(6'h00, 1'b0, 1'b0);
        repeat (4) step(6'h00, 1'b1, 1'b0);
        // MEM_WRITE timeout
        repeat (3) step(6'h2B, 1'b1, 1'b0);
        repeat (TO) step(6'h2B, 1'b0, 1'b0);
        step(6'h2B, 1'b1, 1'b0);
        do_reset();

        // randomized instruction stream
        cur_op = 6'h00;
        errc   = 0;
        for (int i = 0; i < 700; i++) begin
            if (m_state == 15) errc++;
            else               errc = 0;
            if (errc > 3) begin
                do_reset();
                errc = 0;
            end else begin
                if (m_state == 0) begin
                    if ($urandom_range(0, 19) < 19) cur_op = ops[$urandom_range(0, 5)];
                    else                            cur_op = 6'($urandom_range(0, 63));
                end
                step(cur_op, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            end
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
